// File: rtl/cme_frame_loader.sv
// Streams a 29-word portfolio frame into the CME slave port, waits a settle
// interval, reads back the initial margin and hands it to a valid/ready consumer.
module cme_frame_loader #(
  parameter int SETTLE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic        cme_chipselect,
  output logic        cme_write,
  output logic        cme_read,
  output logic [4:0]  cme_offset,
  output logic [15:0] cme_writedata,
  input  logic [15:0] cme_readdata,
  output logic [15:0] margin_data,
  output logic        margin_valid,
  input  logic        margin_ready,
  output logic        busy,
  output logic        frame_err
);

  // state  | meaning
  // IDLE   | waiting for the first word of a frame
  // CLEAR  | offset-29 write on the bus, drops engine start flags
  // LOAD   | accepting words 0..28, one register write per word
  // SETTLE | engine computing, down-counter runs SETTLE_CYCLES
  // READ   | margin read strobe on the bus
  // WAIT   | engine registers read data
  // OUT    | margin presented until consumer takes it
  typedef enum logic [2:0] {IDLE, CLEAR, LOAD, SETTLE, READ, WAIT, OUT} state_t;

  localparam logic [4:0] LAST_WORD    = 5'd28;
  localparam logic [4:0] CLEAR_OFFSET = 5'd29;
  localparam logic [7:0] SETTLE_LOAD  = 8'(SETTLE_CYCLES - 1);

  state_t      state, state_nxt;
  logic [4:0]  word_cnt, word_cnt_nxt;
  logic [7:0]  settle_cnt, settle_cnt_nxt;
  logic        cs_nxt, wr_nxt, rd_nxt, err_nxt, mvalid_nxt;
  logic [4:0]  offset_nxt;
  logic [15:0] wdata_nxt, mdata_nxt;
  logic        accept;

  assign in_ready = (state == LOAD);
  assign busy     = (state != IDLE);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_nxt      = state;
    word_cnt_nxt   = word_cnt;
    settle_cnt_nxt = settle_cnt;
    cs_nxt         = 1'b0;
    wr_nxt         = 1'b0;
    rd_nxt         = 1'b0;
    err_nxt        = 1'b0;
    offset_nxt     = cme_offset;
    wdata_nxt      = cme_writedata;
    mdata_nxt      = margin_data;
    mvalid_nxt     = margin_valid;
    case (state)
      IDLE: if (in_valid) begin
        state_nxt    = CLEAR;
        word_cnt_nxt = '0;
        cs_nxt       = 1'b1;
        wr_nxt       = 1'b1;
        offset_nxt   = CLEAR_OFFSET;
        wdata_nxt    = '0;
      end
      CLEAR: state_nxt = LOAD;
      LOAD: if (accept) begin
        cs_nxt     = 1'b1;
        wr_nxt     = 1'b1;
        offset_nxt = word_cnt;
        wdata_nxt  = in_data;
        // word 28 always completes the frame; a missing in_last is only flagged
        if (word_cnt == LAST_WORD) begin
          state_nxt      = SETTLE;
          settle_cnt_nxt = SETTLE_LOAD;
          err_nxt        = !in_last;
        end else begin
          word_cnt_nxt = word_cnt + 5'd1;
          if (in_last) begin
            err_nxt   = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      SETTLE: if (settle_cnt == 8'd0) begin
        state_nxt  = READ;
        cs_nxt     = 1'b1;
        rd_nxt     = 1'b1;
        offset_nxt = '0;
      end else begin
        settle_cnt_nxt = settle_cnt - 8'd1;
      end
      READ: state_nxt = WAIT;
      WAIT: begin
        mdata_nxt  = cme_readdata;
        mvalid_nxt = 1'b1;
        state_nxt  = OUT;
      end
      OUT: if (margin_ready) begin
        mvalid_nxt = 1'b0;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      word_cnt       <= '0;
      settle_cnt     <= '0;
      cme_chipselect <= 1'b0;
      cme_write      <= 1'b0;
      cme_read       <= 1'b0;
      cme_offset     <= '0;
      cme_writedata  <= '0;
      margin_data    <= '0;
      margin_valid   <= 1'b0;
      frame_err      <= 1'b0;
    end else begin
      state          <= state_nxt;
      word_cnt       <= word_cnt_nxt;
      settle_cnt     <= settle_cnt_nxt;
      cme_chipselect <= cs_nxt;
      cme_write      <= wr_nxt;
      cme_read       <= rd_nxt;
      cme_offset     <= offset_nxt;
      cme_writedata  <= wdata_nxt;
      margin_data    <= mdata_nxt;
      margin_valid   <= mvalid_nxt;
      frame_err      <= err_nxt;
    end
  end

endmodule

// File: tb/tb_cme_frame_loader.sv
// Bench for cme_frame_loader: per-frame event schedule computed from the frame
// timing rules, compared against the DUT every cycle, plus pinned event cycles.
module tb_cme_frame_loader;
  localparam int S    = 16;
  localparam int MAXC = 8192;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] in_data;
  logic        in_valid, in_last, in_ready;
  logic        cme_chipselect, cme_write, cme_read;
  logic [4:0]  cme_offset;
  logic [15:0] cme_writedata, cme_readdata;
  logic [15:0] margin_data;
  logic        margin_valid, margin_ready, busy, frame_err;

  cme_frame_loader #(.SETTLE_CYCLES(S)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .cme_chipselect(cme_chipselect), .cme_write(cme_write), .cme_read(cme_read),
    .cme_offset(cme_offset), .cme_writedata(cme_writedata), .cme_readdata(cme_readdata),
    .margin_data(margin_data), .margin_valid(margin_valid), .margin_ready(margin_ready),
    .busy(busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // engine slave: read data registered one cycle after the strobe, noise otherwise
  logic [15:0] engine_margin;
  always @(posedge clk)
    cme_readdata <= (cme_chipselect && cme_read) ? engine_margin : 16'($urandom);

  logic        e_busy[MAXC], e_rdy[MAXC], e_cs[MAXC], e_wr[MAXC], e_rd[MAXC], e_mv[MAXC], e_err[MAXC];
  logic [4:0]  e_off[MAXC];
  logic [15:0] e_wd[MAXC], e_md[MAXC];
  logic        o_wr[MAXC], o_rd[MAXC], o_mv[MAXC], o_err[MAXC], o_busy[MAXC];
  logic [4:0]  o_off[MAXC];
  logic        p_iv[MAXC], p_il[MAXC], p_mr[MAXC], p_rs[MAXC];
  logic [15:0] p_id[MAXC];

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %0h, expected %0h", nm, c, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en && cyc < MAXC) begin
      o_wr[cyc]   <= cme_write;
      o_rd[cyc]   <= cme_read;
      o_mv[cyc]   <= margin_valid;
      o_err[cyc]  <= frame_err;
      o_busy[cyc] <= busy;
      o_off[cyc]  <= cme_offset;
      chk("busy", cyc, busy, e_busy[cyc]);
      chk("in_ready", cyc, in_ready, e_rdy[cyc]);
      chk("chipselect", cyc, cme_chipselect, e_cs[cyc]);
      chk("write", cyc, cme_write, e_wr[cyc]);
      chk("read", cyc, cme_read, e_rd[cyc]);
      chk("frame_err", cyc, frame_err, e_err[cyc]);
      chk("margin_valid", cyc, margin_valid, e_mv[cyc]);
      chk("margin_data", cyc, margin_data, e_md[cyc]);
      if (e_cs[cyc] && e_wr[cyc]) begin
        chk("wr_offset", cyc, cme_offset, e_off[cyc]);
        chk("wr_data", cyc, cme_writedata, e_wd[cyc]);
      end
      if (e_rd[cyc]) chk("rd_offset", cyc, cme_offset, 5'd0);
    end
  end

  function automatic int first_rd(input int from, input int to);
    for (int t = from; t < to && t < MAXC; t++) if (o_rd[t] === 1'b1) return t;
    return -1;
  endfunction
  function automatic int first_mv(input int from, input int to);
    for (int t = from; t < to && t < MAXC; t++) if (o_mv[t] === 1'b1) return t;
    return -1;
  endfunction
  function automatic int first_err(input int from, input int to);
    for (int t = from; t < to && t < MAXC; t++) if (o_err[t] === 1'b1) return t;
    return -1;
  endfunction
  function automatic int first_clear(input int from, input int to);
    for (int t = from; t < to && t < MAXC; t++)
      if (o_wr[t] === 1'b1 && o_off[t] === 5'd29) return t;
    return -1;
  endfunction
  function automatic int count_err(input int from, input int to);
    int n = 0;
    for (int t = from; t < to && t < MAXC; t++) if (o_err[t] === 1'b1) n++;
    return n;
  endfunction
  function automatic int count_rd(input int from, input int to);
    int n = 0;
    for (int t = from; t < to && t < MAXC; t++) if (o_rd[t] === 1'b1) n++;
    return n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input int t);
    reset        = p_rs[t];
    in_valid     = p_iv[t];
    in_data      = p_id[t];
    in_last      = p_il[t];
    margin_ready = p_mr[t];
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      reset        = 1'b0;
      in_valid     = 1'b0;
      in_last      = 1'($urandom_range(0, 1));
      in_data      = 16'($urandom);
      margin_ready = 1'($urandom_range(0, 1));
      tick();
    end
  endtask

  // Called at the start of a cycle with the DUT idle. last_word<0 means no in_last
  // at all; rst_word>=0 asserts reset in the cycle that word would be accepted.
  task automatic run_frame(input int last_word, input int gap_after, input int gap_len,
                           input int stall, input bit hold_valid, input int rst_word,
                           input bit seq_data, input logic [15:0] margin,
                           output int c0, output int fe);
    int acc[29];
    logic [15:0] words[29];
    int nwords, a, endc, r, x;
    c0 = cyc;
    fe = c0;
    if (c0 > MAXC - 200) begin
      $display("FAIL cycle_budget cycle %0d: got %0d, expected below %0d", c0, c0, MAXC - 200);
      $fatal(1);
    end
    nwords = (last_word >= 0 && last_word < 28) ? last_word + 1 : 29;
    engine_margin = margin;
    for (int k = 0; k < 29; k++) words[k] = seq_data ? 16'(16'h0100 + k) : 16'($urandom);
    for (int t = c0; t < c0 + 120 + stall; t++) begin
      p_rs[t] = 1'b0;
      p_iv[t] = hold_valid ? 1'b1 : 1'($urandom_range(0, 1));
      p_id[t] = 16'($urandom);
      p_il[t] = 1'($urandom_range(0, 1));
      p_mr[t] = 1'($urandom_range(0, 1));
    end
    p_iv[c0]      = 1'b1;
    e_busy[c0+1]  = 1'b1;
    e_cs[c0+1]    = 1'b1;
    e_wr[c0+1]    = 1'b1;
    e_off[c0+1]   = 5'd29;
    e_wd[c0+1]    = 16'h0000;
    a = c0 + 2;
    for (int k = 0; k < nwords; k++) begin
      acc[k]     = a;
      p_iv[a]    = 1'b1;
      p_id[a]    = words[k];
      p_il[a]    = (k == last_word);
      e_rdy[a]   = 1'b1;
      e_busy[a]  = 1'b1;
      e_cs[a+1]  = 1'b1;
      e_wr[a+1]  = 1'b1;
      e_off[a+1] = 5'(k);
      e_wd[a+1]  = words[k];
      a++;
      if (k == gap_after && k < nwords - 1)
        for (int g = 0; g < gap_len; g++) begin
          p_iv[a]   = 1'b0;
          e_rdy[a]  = 1'b1;
          e_busy[a] = 1'b1;
          a++;
        end
    end
    endc = acc[nwords-1];
    if (nwords < 29) begin
      e_err[endc+1] = 1'b1;
      fe = endc + 1;
    end else begin
      for (int t = endc + 1; t <= endc + S; t++) e_busy[t] = 1'b1;
      if (last_word < 0) e_err[endc+1] = 1'b1;
      r = endc + 1 + S;
      e_busy[r]   = 1'b1;
      e_cs[r]     = 1'b1;
      e_rd[r]     = 1'b1;
      e_busy[r+1] = 1'b1;
      for (int t = r + 2; t <= r + 2 + stall; t++) begin
        e_busy[t] = 1'b1;
        e_mv[t]   = 1'b1;
        p_mr[t]   = (t == r + 2 + stall);
      end
      for (int t = r + 2; t < MAXC; t++) e_md[t] = margin;
      fe = r + 3 + stall;
    end
    if (rst_word >= 0 && rst_word < nwords) begin
      x = acc[rst_word];
      for (int t = x; t < MAXC; t++) begin
        e_busy[t] = 1'b0; e_rdy[t] = 1'b0; e_cs[t] = 1'b0; e_wr[t] = 1'b0;
        e_rd[t] = 1'b0; e_mv[t] = 1'b0; e_err[t] = 1'b0; e_md[t] = 16'h0000;
      end
      p_rs[x] = 1'b1; p_rs[x+1] = 1'b1;
      p_iv[x] = 1'b0; p_iv[x+1] = 1'b0;
      fe = x + 2;
    end
    for (int t = c0; t < fe; t++) begin
      apply(t);
      tick();
    end
  endtask

  initial begin
    int c0, fe, c1, fe1;
    int lw, ga, gl, st;
    for (int t = 0; t < MAXC; t++) begin
      e_busy[t] = 1'b0; e_rdy[t] = 1'b0; e_cs[t] = 1'b0; e_wr[t] = 1'b0; e_rd[t] = 1'b0;
      e_mv[t] = 1'b0; e_err[t] = 1'b0; e_off[t] = 5'd0; e_wd[t] = 16'h0000; e_md[t] = 16'h0000;
      o_wr[t] = 1'b0; o_rd[t] = 1'b0; o_mv[t] = 1'b0; o_err[t] = 1'b0; o_busy[t] = 1'b0; o_off[t] = 5'd0;
      p_iv[t] = 1'b0; p_il[t] = 1'b0; p_mr[t] = 1'b0; p_rs[t] = 1'b0; p_id[t] = 16'h0000;
    end
    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = 16'h0000;
    margin_ready = 1'b0; engine_margin = 16'h0000;
    chk_en = 1'b1;
    tick(); tick(); tick();
    idle(2);

    // nominal frame
    run_frame(28, -1, 0, 0, 1'b1, -1, 1'b1, 16'h1234, c0, fe);
    chk("nom_clear_write", c0 + 1, {o_wr[c0+1], o_off[c0+1]}, {1'b1, 5'd29});
    chk("nom_w28_write", c0 + 31, {o_wr[c0+31], o_off[c0+31]}, {1'b1, 5'd28});
    chk("nom_rd_cycle", c0, first_rd(c0, fe) - c0, 47);
    chk("nom_mv_cycle", c0, first_mv(c0, fe) - c0, 49);
    chk("model_pin_mv", c0 + 49, {e_mv[c0+49], e_md[c0+49]}, {1'b1, 16'h1234});
    idle(2);

    // three-cycle input gap after word 10
    run_frame(28, 10, 3, 0, 1'b0, -1, 1'b0, 16'hbeef, c0, fe);
    chk("stall_mv_cycle", c0, first_mv(c0, fe) - c0, 52);
    chk("model_pin_stall_rd", c0 + 50, e_rd[c0+50], 1'b1);
    idle(1);

    // early in_last on word 5
    run_frame(5, -1, 0, 0, 1'b0, -1, 1'b0, 16'h0f0f, c0, fe);
    idle(3);
    chk("early_err_count", c0, count_err(c0, c0 + 11), 1);
    chk("early_no_read", c0, count_rd(c0, c0 + 11), 0);
    chk("early_busy_low", c0 + 9, o_busy[c0+9], 1'b0);

    // word 28 without in_last
    run_frame(-1, -1, 0, 0, 1'b0, -1, 1'b0, 16'h5a5a, c0, fe);
    chk("nolast_err_cycle", c0, first_err(c0, fe) - c0, 31);
    chk("nolast_mv_cycle", c0, first_mv(c0, fe) - c0, 49);
    idle(2);

    // ten-cycle margin backpressure with in_valid held, next frame back to back
    run_frame(28, -1, 0, 10, 1'b1, -1, 1'b0, 16'hc3c3, c0, fe);
    run_frame(28, -1, 0, 0, 1'b0, -1, 1'b0, 16'h7777, c1, fe1);
    chk("bp_clear_after_ready", c0, first_clear(c0 + 50, fe1) - (c0 + 59), 2);
    chk("bp_next_mv_cycle", c1, first_mv(c1, fe1) - c1, 49);
    idle(1);

    // reset in the cycle word 12 would be accepted, then a full frame
    run_frame(28, -1, 0, 0, 1'b1, 12, 1'b0, 16'h4444, c0, fe);
    chk("rst_bus_zero", c0 + 14, {o_wr[c0+14], o_busy[c0+14]}, 2'b00);
    run_frame(28, -1, 0, 0, 1'b1, -1, 1'b1, 16'h9999, c1, fe1);
    chk("post_rst_rd_cycle", c1, first_rd(c1, fe1) - c1, 47);
    chk("post_rst_mv_cycle", c1, first_mv(c1, fe1) - c1, 49);
    idle(1);

    // randomized frames
    for (int n = 0; n < 16; n++) begin
      case ($urandom_range(0, 9))
        0:       lw = int'($urandom_range(0, 27));
        1:       lw = -1;
        default: lw = 28;
      endcase
      ga = int'($urandom_range(0, 27));
      gl = int'($urandom_range(0, 4));
      st = int'($urandom_range(0, 6));
      run_frame(lw, ga, gl, st, 1'($urandom_range(0, 1)), -1, 1'b0, 16'($urandom), c0, fe);
      idle(int'($urandom_range(0, 3)));
    end

    idle(3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/cme_frame_loader.md
# cme_frame_loader

Upstream sequencer for the SPAN margin engine. It accepts one portfolio frame as a valid/ready stream of 29 sixteen-bit words and replays it as register writes into the margin engine's slave port at offsets 0–28. It then waits a programmable settle time, reads back the 16-bit initial margin, and presents the result on a valid/ready output. It owns the clear/start sequencing, so software only pushes words and pops margins.

## Interface
Parameters:
- SETTLE_CYCLES, 16, cycles waited after the final write before the margin read; legal range 1–255.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- in_data  in  16  frame word; word k is written to engine offset k
- in_valid  in  1  in_data valid
- in_last  in  1  marks the final word of a frame
- in_ready  out  1  loader accepts a word this cycle
- cme_chipselect  out  1  engine slave chipselect
- cme_write  out  1  engine slave write strobe
- cme_read  out  1  engine slave read strobe
- cme_offset  out  5  engine register offset
- cme_writedata  out  16  engine write data
- cme_readdata  in  16  engine read data; registered by the engine one cycle after the read strobe
- margin_data  out  16  captured initial margin
- margin_valid  out  1  margin_data valid
- margin_ready  in  1  consumer accepts margin_data
- busy  out  1  high in every state except IDLE
- frame_err  out  1  one-cycle pulse on a framing error

## Operation
- The clock is clk. Reset is asynchronous and active-high.
- All cme_* outputs, margin_data and margin_valid are registers.
- States: IDLE, CLEAR, LOAD, SETTLE, READ, WAIT, OUT.
- **IDLE**
  - in_ready=0.
  - When in_valid=1, go to CLEAR and load the write registers with offset 29, data 0.
  - The offset-29 write hits the engine's default case, which drops both start flags before the new frame.
- **CLEAR**
  - Lasts one cycle.
  - The offset-29 write is visible on the bus this cycle.
  - Go to LOAD.
- **LOAD**
  - in_ready=1.
  - Each accepted word (in_valid && in_ready) loads cme_offset=word_cnt and cme_writedata=in_data, with cme_write=cme_chipselect=1 in the next cycle.
  - word_cnt (5 bits) counts 0–28.
  - When no word is accepted, the next cycle has cme_write=cme_chipselect=0.
  - Back-to-back words produce back-to-back writes.
- **Early end of frame**
  - in_last=1 on a word with word_cnt<28 still writes that word.
  - frame_err pulses, and the state returns to IDLE. No settle or read occurs.
- **Word 28**
  - Acceptance of word 28 moves the state to SETTLE.
  - If in_last=0 on that word, frame_err pulses but the frame proceeds.
  - The engine's start strobes fire on its own writes to offsets 8 and 28.
- **SETTLE**
  - The offset-28 write occupies the first SETTLE cycle.
  - An 8-bit counter holds the state for exactly SETTLE_CYCLES cycles, then goes to READ.
- **READ**
  - cme_chipselect=cme_read=1 for one cycle.
  - cme_write=0.
  - cme_offset=0.
- **WAIT**
  - Lasts one cycle.
  - At the end of this cycle, cme_readdata is captured into margin_data and margin_valid is set.
- **OUT**
  - margin_valid=1 and margin_data is held stable until margin_ready=1.
  - On margin_ready=1, margin_valid clears in the next cycle and the state returns to IDLE.
  - in_ready=0 throughout OUT. A pending in_valid is accepted only after the return to IDLE.
- **Arithmetic**
  - No arithmetic on data; words are passed through unmodified.
  - Counters never wrap; word_cnt clears on entry to CLEAR.

## Timing
- **Reset**
  - Outputs: all cme_* = 0, margin_data = 0, margin_valid = 0, in_ready = 0, busy = 0, frame_err = 0.
  - Internal: state = IDLE, word_cnt = 0, settle counter = 0.
- **Reset asserted mid-frame**
  - All outputs drop immediately.
  - No further writes or reads are issued.
  - Partially written engine registers are not cleaned up by the loader.
- **Latency reference:** in_valid first seen in IDLE at cycle 0, in_valid continuously high, S = SETTLE_CYCLES.
  - Cycle 1: CLEAR write.
  - Cycle 2+k: word k accepted.
  - Cycle 3+k: write of offset k visible.
  - Cycle 31: write of offset 28 visible.
  - Cycle 31+S: READ.
  - Cycle 33+S: margin_valid high. This is cycle 49 for S=16.
- **Input stalls:** an in_valid gap of g cycles delays every later event by g.
- **Output backpressure:** margin_valid is never dropped without margin_ready.

## Test plan
- **Nominal frame:** reset, then stream words 0..28 with value 0x0100+k, in_last on word 28; engine model returns 0x1234.
  - Required: writes at offsets 29, 0, 1, ..., 28 in cycles 1, 3..31.
  - Required: read strobe at cycle 47; margin_valid at cycle 49 with margin_data=0x1234.
- **Input stalls:** drop in_valid for 3 cycles after word 10.
  - Required: writes stay in order with a 3-cycle gap.
  - Required: margin_valid at cycle 52.
- **Early in_last:** assert in_last on word 5.
  - Required: offsets 29, 0..5 written; frame_err pulses once.
  - Required: no read strobe; busy=0 two cycles later.
- **Missing in_last:** in_last=0 on word 28.
  - Required: frame_err pulses in the cycle after word 28 is accepted.
  - Required: read still occurs and margin is delivered.
- **Output backpressure:** hold margin_ready=0 for 10 cycles with in_valid=1.
  - Required: margin_data stable and in_ready=0 during the stall.
  - Required: the next frame's CLEAR write occurs 2 cycles after margin_ready rises.
- **Reset mid-LOAD:** assert reset at word 12.
  - Required: all outputs 0 the same cycle.
  - Required: after release, a full frame completes with nominal timing.
